// File: rtl/green_seq_if.sv
// green_seq memory bus: instruction fetch handshake plus data memory write port.
// The sequencer is the master; the memory side is the slave.
interface green_seq_if #(
    parameter int AW = 8
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [15:0]   imem_data;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [15:0]   dmem_wdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata
    );
endinterface

// File: rtl/green_seq.sv
// green_seq: fetch/execute sequencer and architectural state (PC, IR, RA, RB)
// for the green circuit. Feeds the external green decoder and commits its
// RA_OUT/RB_OUT/WE/BR results at the end of every EXEC cycle.
module green_seq #(
    parameter int            AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    green_seq_if.master        bus,
    output logic [15:0]        ins,
    output logic [15:0]        ra_q,
    output logic [15:0]        rb_q,
    output logic [15:0]        inca,
    output logic [15:0]        incb,
    output logic [15:0]        ld,
    output logic               branch,
    input  logic [15:0]        ra_next,
    input  logic [15:0]        rb_next,
    input  logic               we,
    input  logic               br,
    output logic               halted
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [AW-1:0] PC_ONE = AW'(1);

    logic [1:0]    r_state;
    logic [AW-1:0] r_pc;
    logic [15:0]   r_ir;
    logic [15:0]   r_ra;
    logic [15:0]   r_rb;

    logic          w_isHalt;
    logic          w_inExec;
    logic          w_commit;
    logic          w_fetchDone;
    logic [AW-1:0] w_pcNext;

    // Decode the control conditions shared by the sequential blocks below.
    always_comb begin
        w_isHalt    = (r_ir[15:12] == 4'hF);
        w_inExec    = (r_state == ST_EXEC);
        w_commit    = w_inExec && !w_isHalt;
        w_fetchDone = (r_state == ST_FETCH) && bus.imem_ack;
        w_pcNext    = br ? r_ir[AW-1:0] : (r_pc + PC_ONE);
    end

    // Sequencer state: IDLE waits for run, FETCH waits for ack, EXEC is one cycle,
    // HALT is terminal until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (run) r_state <= ST_FETCH;
                ST_FETCH: if (bus.imem_ack) r_state <= ST_EXEC;
                ST_EXEC: begin
                    if (w_isHalt)  r_state <= ST_HALT;
                    else if (run)  r_state <= ST_FETCH;
                    else           r_state <= ST_IDLE;
                end
                default:  r_state <= ST_HALT;
            endcase
        end
    end

    // Program counter advances (or branches) only when a non-halt instruction commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (w_commit) begin
            r_pc <= w_pcNext;
        end
    end

    // Instruction register captures fetched data on the acknowledging FETCH cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir <= '0;
        end else if (w_fetchDone) begin
            r_ir <= bus.imem_data;
        end
    end

    // RA/RB take the decoder results at the end of a committing EXEC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ra <= '0;
            r_rb <= '0;
        end else if (w_commit) begin
            r_ra <= ra_next;
            r_rb <= rb_next;
        end
    end

    // Decoder-facing values are derived from the current registers in every state.
    always_comb begin
        ins    = r_ir;
        ra_q   = r_ra;
        rb_q   = r_rb;
        inca   = r_ra + 16'd1;
        incb   = r_rb + 16'd1;
        ld     = {5'b0, r_ir[10:0]};
        branch = (r_ra == r_rb);
        halted = (r_state == ST_HALT);
    end

    // Memory bus: fetch request in FETCH only, data write only from a non-halt EXEC.
    always_comb begin
        bus.imem_req   = (r_state == ST_FETCH);
        bus.imem_addr  = r_pc;
        bus.dmem_we    = w_commit && we;
        bus.dmem_addr  = r_ir[AW-1:0];
        bus.dmem_wdata = r_ra;
    end

endmodule

// File: tb/tb_green_seq.sv
// tb_green_seq: scoreboard bench for green_seq with a behavioural green decoder
// and an instruction memory responder with programmable wait states.
module tb_green_seq;

    localparam int TB_AW = 8;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] ins, ra_q, rb_q, inca, incb, ld;
    logic        branch, halted;
    logic [15:0] decRa, decRb;
    logic        decWe, decBr;

    green_seq_if #(.AW(TB_AW)) bus ();

    green_seq #(.AW(TB_AW), .RESET_PC(8'h00)) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .bus     (bus),
        .ins     (ins),
        .ra_q    (ra_q),
        .rb_q    (rb_q),
        .inca    (inca),
        .incb    (incb),
        .ld      (ld),
        .branch  (branch),
        .ra_next (decRa),
        .rb_next (decRb),
        .we      (decWe),
        .br      (decBr),
        .halted  (halted)
    );

    logic [15:0] mem [0:255];
    logic [7:0]  fetchQ [$];
    logic [23:0] dmemQ [$];
    logic [15:0] raQ [$];
    int          checkCount = 0;
    int          errorCount = 0;
    int          cycle = 0;
    int          waitCycles = 0;
    bit          checkPeriod = 0;

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle counter
    initial begin
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    // Watchdog in case a bounded wait is somehow bypassed
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Behavioural green decoder: 0=load imm (ins[11] picks RB), 1=store RA,
    // 2=increment (ins[11] picks RB), 3=branch if RA==RB, others pass through.
    always_comb begin
        decRa = ra_q;
        decRb = rb_q;
        decWe = 1'b0;
        decBr = 1'b0;
        case (ins[15:12])
            4'h0: if (ins[11]) decRb = ld; else decRa = ld;
            4'h1: decWe = 1'b1;
            4'h2: if (ins[11]) decRb = incb; else decRa = inca;
            4'h3: decBr = branch;
            default: ;
        endcase
    end

    // Instruction memory responder: acks after waitCycles idle cycles, pops
    // the expected fetch address and checks the request address and period.
    initial begin
        int waitCnt;
        int prevAck;
        bit prevAckValid;
        waitCnt = 0;
        prevAck = 0;
        prevAckValid = 0;
        bus.imem_ack = 1'b0;
        bus.imem_data = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus.imem_ack = 1'b0;
                waitCnt = 0;
                prevAckValid = 0;
            end else if (bus.imem_req) begin
                if (waitCnt >= waitCycles) begin
                    bus.imem_ack = 1'b1;
                    bus.imem_data = mem[bus.imem_addr];
                    waitCnt = 0;
                    if (fetchQ.size() == 0) begin
                        checkOutput("fetchUnexpected", {24'h0, bus.imem_addr}, 32'hFFFF_FFFF);
                    end else begin
                        checkOutput("fetchAddr", {24'h0, bus.imem_addr}, {24'h0, fetchQ.pop_front()});
                    end
                    if (checkPeriod && prevAckValid)
                        checkOutput("fetchPeriod", cycle - prevAck, waitCycles + 2);
                    prevAck = cycle;
                    prevAckValid = 1;
                end else begin
                    bus.imem_ack = 1'b0;
                    waitCnt++;
                    if (fetchQ.size() != 0)
                        checkOutput("fetchAddrWait", {24'h0, bus.imem_addr}, {24'h0, fetchQ[0]});
                end
            end else begin
                bus.imem_ack = 1'b0;
                waitCnt = 0;
            end
        end
    end

    // Data memory write monitor against the expected-write queue
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.dmem_we === 1'b1) begin
                if (dmemQ.size() == 0) begin
                    checkOutput("dmemUnexpected", {8'h0, bus.dmem_addr, bus.dmem_wdata}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("dmemWrite", {8'h0, bus.dmem_addr, bus.dmem_wdata}, {8'h0, dmemQ.pop_front()});
                end
            end
        end
    end

    // RA history monitor: every committed change must match the next expected value
    initial begin
        logic [15:0] prevRa;
        prevRa = 16'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevRa = ra_q;
            end else if (ra_q !== prevRa) begin
                if (raQ.size() == 0) checkOutput("raUnexpected", {16'h0, ra_q}, 32'hFFFF_FFFF);
                else                 checkOutput("raHistory", {16'h0, ra_q}, {16'h0, raQ.pop_front()});
                prevRa = ra_q;
            end
        end
    end

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    task automatic loadMainProgram(input bit expectStore, input bit expectHaltFetch);
        clearMem();
        mem[0] = 16'h0005; mem[1] = 16'h0805; mem[2] = 16'h3007;
        mem[7] = 16'h2000; mem[8] = 16'h1020; mem[9] = 16'hF000;
        fetchQ.push_back(8'h00); fetchQ.push_back(8'h01); fetchQ.push_back(8'h02);
        fetchQ.push_back(8'h07); fetchQ.push_back(8'h08);
        if (expectHaltFetch) fetchQ.push_back(8'h09);
        if (expectStore) dmemQ.push_back({8'h20, 16'h0006});
        raQ.push_back(16'h0005); raQ.push_back(16'h0006);
    endtask

    task automatic applyStimulus(input int waits, input bit periodCheck);
        waitCycles = waits;
        checkPeriod = periodCheck;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
    endtask

    task automatic waitHalt(input string tag, input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (halted === 1'b1) found = 1;
        end
        checkOutput(tag, {31'h0, found}, 32'h1);
    endtask

    task automatic waitFetchOf(input string tag, input logic [7:0] addr, input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (bus.imem_req === 1'b1 && bus.imem_addr === addr) found = 1;
        end
        checkOutput(tag, {31'h0, found}, 32'h1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "Req"},    {31'h0, bus.imem_req}, 32'h0);
        checkOutput({tag, "DmemWe"}, {31'h0, bus.dmem_we}, 32'h0);
        checkOutput({tag, "Halted"}, {31'h0, halted}, 32'h0);
        checkOutput({tag, "Ins"},    {16'h0, ins}, 32'h0);
        checkOutput({tag, "Ld"},     {16'h0, ld}, 32'h0);
        checkOutput({tag, "Inca"},   {16'h0, inca}, 32'h1);
        checkOutput({tag, "Incb"},   {16'h0, incb}, 32'h1);
        checkOutput({tag, "Branch"}, {31'h0, branch}, 32'h1);
        checkOutput({tag, "Pc"},     {24'h0, bus.imem_addr}, 32'h0);
        checkOutput({tag, "Ra"},     {16'h0, ra_q}, 32'h0);
        checkOutput({tag, "Rb"},     {16'h0, rb_q}, 32'h0);
    endtask

    task automatic checkQueuesDrained(input string tag);
        checkOutput({tag, "FetchQ"}, fetchQ.size(), 0);
        checkOutput({tag, "DmemQ"},  dmemQ.size(), 0);
        checkOutput({tag, "RaQ"},    raQ.size(), 0);
        fetchQ.delete();
        dmemQ.delete();
        raQ.delete();
    endtask

    task automatic checkHaltedState(input string tag);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput({tag, "HaltReq"}, {31'h0, bus.imem_req}, 32'h0);
            checkOutput({tag, "Halted"},  {31'h0, halted}, 32'h1);
        end
        checkOutput({tag, "Ra"}, {16'h0, ra_q}, 32'h6);
        checkOutput({tag, "Rb"}, {16'h0, rb_q}, 32'h5);
        checkOutput({tag, "Pc"}, {24'h0, bus.imem_addr}, 32'h9);
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        clearMem();
        repeat (2) @(negedge clk);
        checkResetValues("rstInit");

        // Reset held mid-FETCH with no ack, then release with run low
        waitCycles = 1000;
        rst = 1'b0;
        run = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("s1FetchReq", {31'h0, bus.imem_req}, 32'h1);
        rst = 1'b1;
        #1;
        checkResetValues("s1Rst");
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("s1IdleReq", {31'h0, bus.imem_req}, 32'h0);
        checkOutput("s1IdlePc", {24'h0, bus.imem_addr}, 32'h0);

        // Zero-wait program run to halt
        loadMainProgram(1, 1);
        applyStimulus(0, 1);
        waitHalt("s2Halt", 100);
        checkHaltedState("s2");
        checkQueuesDrained("s2");

        // Same program with 3 wait states per fetch
        loadMainProgram(1, 1);
        applyStimulus(3, 1);
        waitHalt("s3Halt", 200);
        checkHaltedState("s3");
        checkQueuesDrained("s3");

        // Branch not taken at pc=5
        clearMem();
        mem[0] = 16'h0001; mem[1] = 16'h0802; mem[2] = 16'h4000; mem[3] = 16'h4000;
        mem[4] = 16'h4000; mem[5] = 16'h3007; mem[6] = 16'hF000;
        for (int a = 0; a <= 6; a++) fetchQ.push_back(8'(a));
        raQ.push_back(16'h0001);
        applyStimulus(0, 1);
        waitHalt("s4aHalt", 100);
        checkOutput("s4aPc", {24'h0, bus.imem_addr}, 32'h6);
        checkOutput("s4aBranch", {31'h0, branch}, 32'h0);
        checkOutput("s4aIncb", {16'h0, incb}, 32'h3);
        checkQueuesDrained("s4a");

        // PC wrap from 0xFF on a no-op
        clearMem();
        mem[0] = 16'h30FF; mem[255] = 16'h4000;
        fetchQ.push_back(8'h00); fetchQ.push_back(8'hFF);
        applyStimulus(0, 1);
        waitFetchOf("s4bFetchFF", 8'hFF, 50);
        run = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("s4bIdleReq", {31'h0, bus.imem_req}, 32'h0);
        checkOutput("s4bPcWrap", {24'h0, bus.imem_addr}, 32'h0);
        checkOutput("s4bLd", {16'h0, ld}, 32'h0);
        checkQueuesDrained("s4b");

        // Run dropped during fetch of mem[1], then resumed
        loadMainProgram(1, 1);
        applyStimulus(2, 0);
        waitFetchOf("s5FetchOne", 8'h01, 50);
        run = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("s5IdleReq", {31'h0, bus.imem_req}, 32'h0);
        checkOutput("s5IdlePc", {24'h0, bus.imem_addr}, 32'h2);
        checkOutput("s5Rb", {16'h0, rb_q}, 32'h5);
        checkOutput("s5Ins", {16'h0, ins}, 32'h0805);
        checkOutput("s5Ld", {16'h0, ld}, 32'h5);
        checkOutput("s5DmemAddr", {24'h0, bus.dmem_addr}, 32'h5);
        checkOutput("s5DmemWdata", {16'h0, bus.dmem_wdata}, 32'h5);
        run = 1'b1;
        waitHalt("s5Halt", 200);
        checkHaltedState("s5");
        checkQueuesDrained("s5");

        // Asynchronous reset during EXEC of the store
        loadMainProgram(0, 0);
        applyStimulus(0, 1);
        begin
            bit found = 0;
            for (int i = 0; i < 100 && !found; i++) begin
                @(posedge clk);
                #2;
                if (ins === 16'h1020 && bus.imem_req === 1'b0 && halted === 1'b0) found = 1;
            end
            checkOutput("s6FoundExec", {31'h0, found}, 32'h1);
        end
        #1;
        rst = 1'b1;
        #1;
        checkOutput("s6DmemWe", {31'h0, bus.dmem_we}, 32'h0);
        checkOutput("s6Pc", {24'h0, bus.imem_addr}, 32'h0);
        checkOutput("s6Ra", {16'h0, ra_q}, 32'h0);
        checkOutput("s6Rb", {16'h0, rb_q}, 32'h0);
        checkOutput("s6Req", {31'h0, bus.imem_req}, 32'h0);
        run = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkQueuesDrained("s6");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
